// File: rtl/mac_4_pkg.sv
// Shared types and defaults for the mac_4 multiply-accumulate stage.
package mac_4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 4;
    localparam int DEFAULT_VEC_LEN    = 8;
    localparam int DEFAULT_ACC_WIDTH  = 12;

    // Bits needed to hold values 0 .. value-1 (never less than 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mac_4_acc_if.sv
// Operand-in / result-out handshake bundle for mac_4_acc.
interface mac_4_acc_if
    import mac_4_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  acc_out;
    logic                  overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, acc_out, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, acc_out, overflow
    );
endinterface

// File: rtl/mac_4_mul_stage.sv
// Registered unsigned multiplier: captures a*b on each accepted pair.
module mac_4_mul_stage #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    accept,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [2*DATA_WIDTH-1:0] prod_p1,
    output logic                    vld_p1
);
    // Product valid: follows the accept pulse, so idle cycles become bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept && !clear;
        end
    end

    // Product data: only meaningful while vld_p1 is set, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            prod_p1 <= {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
        end
    end
endmodule

// File: rtl/mac_4_acc.sv
// Sequential dot-product accumulator: VEC_LEN pairs in, one sum out.
module mac_4_acc
    import mac_4_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int VEC_LEN    = DEFAULT_VEC_LEN,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    mac_4_acc_if.slave bus
);
    localparam int                CNT_W    = clog2(VEC_LEN + 1);
    localparam int                PROD_W   = 2 * DATA_WIDTH;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(VEC_LEN - 1);

    state_t                state;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  ovf_p2;
    logic [ACC_WIDTH-1:0]  acc_p2;
    logic [CNT_W-1:0]      cnt_q;
    logic                  accept;
    logic [PROD_W-1:0]     prod_p1;
    logic                  vld_p1;
    logic [ACC_WIDTH:0]    sum_p2;

    // Wrapping add with the carry kept in the top bit.
    function automatic logic [ACC_WIDTH:0] acc_add(input logic [ACC_WIDTH-1:0] acc_v,
                                                   input logic [PROD_W-1:0]    p);
        return {1'b0, acc_v} + {{(ACC_WIDTH + 1 - PROD_W){1'b0}}, p};
    endfunction

    // Stage p0 -> p1: operand capture and multiply
    assign accept = bus.in_valid && in_ready_q && !clear;

    mac_4_mul_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .accept  (accept),
        .a       (bus.a),
        .b       (bus.b),
        .prod_p1 (prod_p1),
        .vld_p1  (vld_p1)
    );

    // Stage p1 -> p2: accumulate into the running sum
    assign sum_p2 = acc_add(acc_p2, prod_p1);

    // Control FSM, sample counter, accumulator and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            acc_p2      <= '0;
            ovf_p2      <= 1'b0;
            cnt_q       <= '0;
        end else if (clear) begin
            state       <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            acc_p2      <= '0;
            ovf_p2      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (vld_p1) begin
                acc_p2 <= sum_p2[ACC_WIDTH-1:0];
                if (sum_p2[ACC_WIDTH]) begin
                    ovf_p2 <= 1'b1;
                end
            end
            case (state)
                // in_ready is raised one cycle into ACCUM after leaving IDLE.
                IDLE: begin
                    state <= ACCUM;
                end
                ACCUM: begin
                    in_ready_q <= !(accept && (cnt_q == LAST_IDX));
                    if (accept) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state       <= HOLD;
                    out_valid_q <= 1'b1;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= ACCUM;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        acc_p2      <= '0;
                        ovf_p2      <= 1'b0;
                        cnt_q       <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_p2;
    assign bus.overflow  = ovf_p2;
endmodule

// File: tb/tb_mac_4_acc.sv
// Directed + randomized bench for mac_4_acc: a 12-bit and an 8-bit accumulator
// run side by side on the same operand stream.
module tb_mac_4_acc;
    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int xfers12  = 0;
    int xfers8   = 0;

    logic [3:0] va [4];
    logic [3:0] vb [4];

    mac_4_acc_if #(.DATA_WIDTH(4), .ACC_WIDTH(12)) bus12 ();
    mac_4_acc_if #(.DATA_WIDTH(4), .ACC_WIDTH(8))  bus8 ();

    assign bus12.in_valid  = in_valid;
    assign bus12.a         = a;
    assign bus12.b         = b;
    assign bus12.out_ready = out_ready;
    assign bus8.in_valid   = in_valid;
    assign bus8.a          = a;
    assign bus8.b          = b;
    assign bus8.out_ready  = out_ready;

    mac_4_acc #(.DATA_WIDTH(4), .VEC_LEN(4), .ACC_WIDTH(12)) dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus12)
    );

    mac_4_acc #(.DATA_WIDTH(4), .VEC_LEN(4), .ACC_WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count result transfers on each instance.
    always @(posedge clk) begin
        if (bus12.out_valid && bus12.out_ready) xfers12++;
        if (bus8.out_valid && bus8.out_ready) xfers8++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ov12"}, 32'(bus12.out_valid), 0);
        check({tag, "_ir12"}, 32'(bus12.in_ready), 0);
        check({tag, "_acc12"}, 32'(bus12.acc_out), 0);
        check({tag, "_of12"}, 32'(bus12.overflow), 0);
        check({tag, "_ov8"}, 32'(bus8.out_valid), 0);
        check({tag, "_acc8"}, 32'(bus8.acc_out), 0);
    endtask

    // Offer the four pairs in va/vb with 'gap' idle cycles between them.
    task automatic send_vec(input int gap, input bit keep_valid);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            a        = va[i];
            b        = vb[i];
            in_valid = 1'b1;
            for (int k = 0; k < 20 && !bus12.in_ready; k++) tick();
            check("ready_wait", 32'(bus12.in_ready), 1);
            tick();
        end
        in_valid = keep_valid;
        a        = 4'($urandom_range(0, 15));
        b        = 4'($urandom_range(0, 15));
    endtask

    // Full vector: send, check latency, result, backpressure and transfer.
    task automatic run_vector(input string tag, input int gap, input int hold, input bit keep_valid);
        int total;
        int x12;
        int x8;
        total = 0;
        for (int i = 0; i < 4; i++) total += int'(va[i]) * int'(vb[i]);
        out_ready = (hold == 0);
        send_vec(gap, keep_valid);
        check({tag, "_early"}, 32'(bus12.out_valid), 0);
        check({tag, "_ir_drain"}, 32'(bus12.in_ready), 0);
        tick();
        check({tag, "_ov"}, 32'(bus12.out_valid), 1);
        check({tag, "_acc12"}, 32'(bus12.acc_out), 32'(total % 4096));
        check({tag, "_of12"}, 32'(bus12.overflow), 32'(total >= 4096));
        check({tag, "_acc8"}, 32'(bus8.acc_out), 32'(total % 256));
        check({tag, "_of8"}, 32'(bus8.overflow), 32'(total >= 256));
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "_hold_ov"}, 32'(bus12.out_valid), 1);
            check({tag, "_hold_acc"}, 32'(bus12.acc_out), 32'(total % 4096));
            check({tag, "_hold_ir"}, 32'(bus12.in_ready), 0);
        end
        out_ready = 1'b1;
        x12 = xfers12;
        x8  = xfers8;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_xfer12"}, 32'(xfers12), 32'(x12 + 1));
        check({tag, "_xfer8"}, 32'(xfers8), 32'(x8 + 1));
        check({tag, "_ov_after"}, 32'(bus12.out_valid), 0);
        check({tag, "_ir_after"}, 32'(bus12.in_ready), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        #3;
        check_idle_outputs("reset");
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        check("post_reset_edge1_ir", 32'(bus12.in_ready), 0);
        tick();
        check("post_reset_edge2_ir", 32'(bus12.in_ready), 1);

        // Basic vector: 1*2 + 2*2 + 3*2 + 4*2 = 20
        va = '{4'd1, 4'd2, 4'd3, 4'd4};
        vb = '{4'd2, 4'd2, 4'd2, 4'd2};
        run_vector("basic", 0, 0, 1'b0);

        // Backpressure with in_valid held high during HOLD
        run_vector("bp", 0, 5, 1'b1);

        // Overflow on the 8-bit instance: 4*225 = 900
        va = '{4'd15, 4'd15, 4'd15, 4'd15};
        vb = '{4'd15, 4'd15, 4'd15, 4'd15};
        run_vector("ovf", 0, 0, 1'b0);
        va = '{4'd1, 4'd1, 4'd1, 4'd1};
        vb = '{4'd1, 4'd1, 4'd1, 4'd1};
        run_vector("post_ovf", 0, 1, 1'b0);

        // Bubbles between pairs
        va = '{4'd3, 4'd3, 4'd3, 4'd3};
        vb = '{4'd3, 4'd3, 4'd3, 4'd3};
        run_vector("bubble", 2, 0, 1'b0);

        // Clear mid-vector, with a pair offered in the clear cycle
        for (int i = 0; i < 2; i++) begin
            a        = 4'd15;
            b        = 4'd15;
            in_valid = 1'b1;
            for (int k = 0; k < 20 && !bus12.in_ready; k++) tick();
            check("clr_ready_wait", 32'(bus12.in_ready), 1);
            tick();
        end
        clear    = 1'b1;
        a        = 4'd7;
        b        = 4'd7;
        in_valid = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_acc12", 32'(bus12.acc_out), 0);
        check("clr_of8", 32'(bus8.overflow), 0);
        check("clr_ir", 32'(bus12.in_ready), 1);
        tick();
        check("clr_acc12_settled", 32'(bus12.acc_out), 0);
        run_vector("after_clr", 0, 0, 1'b0);

        // Randomized vectors with random gaps and backpressure
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) begin
                va[i] = 4'($urandom_range(0, 15));
                vb[i] = 4'($urandom_range(0, 15));
            end
            run_vector("rand", int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)));
        end

        // Reset while a result is held
        va = '{4'd5, 4'd6, 4'd7, 4'd8};
        vb = '{4'd9, 4'd9, 4'd9, 4'd9};
        out_ready = 1'b0;
        send_vec(0, 1'b0);
        tick();
        check("rst_hold_ov", 32'(bus12.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_hold");
        tick();
        #3 rst_n = 1'b1;
        tick();
        check("rst_hold_edge1_ir", 32'(bus12.in_ready), 0);
        tick();
        check("rst_hold_edge2_ir", 32'(bus12.in_ready), 1);
        check("rst_hold_ov_after", 32'(bus12.out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
